mem_access_stage: RTL and testbench
===================================

# mem_access_stage

Memory-stage controller for the pipelined RISC-V core. It consumes the registered EX/MEM control and data signals and runs a req/ack handshake with a data memory of variable latency. While an access is outstanding it stalls the upstream pipeline. It then registers the result into the MEM/WB pipeline outputs consumed by write-back.

## Interface
- TIMEOUT_CYC, 255, WAIT-state cycles without ack before an access is abandoned; legal range 1..65535.

- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, asynchronous, active-low
- RegWrite_i  in  1  write-back enable from EX/MEM
- MemtoReg_i  in  1  write-back source select from EX/MEM (1 = memory data)
- MemRead_i  in  1  load request from EX/MEM
- MemWrite_i  in  1  store request from EX/MEM
- ALUout_i  in  32  ALU result / memory byte address from EX/MEM
- DM_writedata_i  in  32  store data from EX/MEM
- rd_i  in  5  destination register from EX/MEM
- dm_req_o  out  1  memory request, held until acknowledged
- dm_we_o  out  1  1 = write, 0 = read; valid while dm_req_o
- dm_addr_o  out  32  access address; valid while dm_req_o
- dm_wdata_o  out  32  write data; valid while dm_req_o
- dm_ack_i  in  1  memory completion, single-cycle pulse
- dm_rdata_i  in  32  read data, valid in the dm_ack_i cycle
- stall_o  out  1  freezes PC, IF/ID, ID/EX and EX/MEM
- RegWrite_o, MemtoReg_o  out  1 each  MEM/WB control
- ALUout_o  out  32  MEM/WB ALU result
- MemData_o  out  32  MEM/WB load data
- rd_o  out  5  MEM/WB destination register
- timeout_o  out  1  sticky error flag: an access timed out

## Operation
- Signal access = MemRead_i | MemWrite_i. If both are set, the access is treated as a write.
- The FSM has two states: IDLE and WAIT. The wait counter is 16 bits wide.
- In IDLE with no access:
  - stall_o = 0.
  - MEM/WB loads RegWrite_i, MemtoReg_i, ALUout_i and rd_i. MemData_o loads 0.
- In IDLE with access:
  - stall_o = 1, driven combinationally.
  - At the next edge: go to WAIT. Register dm_req_o = 1, dm_we_o = MemWrite_i, dm_addr_o = ALUout_i, dm_wdata_o = DM_writedata_i. Clear the counter.
  - MEM/WB loads a bubble: RegWrite_o = 0, MemtoReg_o = 0, rd_o = 0, ALUout_o and MemData_o = 0.
- In WAIT with dm_ack_i = 0:
  - stall_o = 1. dm_req_o and the address/data/we outputs are held stable.
  - The counter increments. MEM/WB loads a bubble each cycle.
- In WAIT with dm_ack_i = 1:
  - stall_o = 0, driven combinationally from dm_ack_i, so EX/MEM advances at this edge.
  - At the edge: go to IDLE and clear dm_req_o.
  - MEM/WB loads the EX/MEM fields. MemData_o = dm_rdata_i for a read, 0 for a write.
- Timeout: in WAIT with no ack and counter == TIMEOUT_CYC-1:
  - Treat the cycle as a completion: stall_o = 0, dm_req_o clears, go to IDLE.
  - MEM/WB loads the EX/MEM fields with MemData_o = 0. timeout_o is set.
- timeout_o is cleared only by reset.
- dm_ack_i in IDLE is ignored.
- dm_rdata_i is ignored outside an ack cycle.

## Timing
- Reset value of every output is 0: dm_*_o, stall_o, all MEM/WB outputs, timeout_o. FSM resets to IDLE and the counter to 0.
- Reset asserted mid-WAIT abandons the access immediately: dm_req_o drops asynchronously.
- Non-memory instruction: MEM/WB is updated 1 cycle after EX/MEM presents it; no stall.
- Memory access acknowledged N cycles after dm_req_o rises (N ≥ 1): stall_o is high for N cycles. The instruction reaches MEM/WB at the edge ending the ack cycle.
  - Minimum penalty is 1 stall cycle.
- dm_req_o rises exactly one edge after the access appears. It never re-asserts for the same instruction, because EX/MEM advances at the completion edge.
- Back-to-back accesses: the next access is seen in IDLE the cycle after completion. dm_req_o is low for exactly 1 cycle between requests.
- stall_o depends combinationally on MemRead_i, MemWrite_i, the FSM state, dm_ack_i and the counter. There is no combinational path from dm_rdata_i.

## Test plan
- Reset, then an ALU-only instruction (RegWrite_i=1, ALUout_i=0x00000010, rd_i=5) → next cycle RegWrite_o=1, ALUout_o=0x10, rd_o=5, MemData_o=0; stall_o never high.
- Load from 0x100 with ack 3 cycles after dm_req_o rises, dm_rdata_i=0xCAFEF00D → stall_o high 3 cycles; dm_we_o=0, dm_addr_o=0x100 held stable; MEM/WB shows bubbles, then RegWrite_o=1, MemtoReg_o=1, MemData_o=0xCAFEF00D.
- Store of 0x12345678 to 0x200, ack in the first WAIT cycle → dm_we_o=1, dm_wdata_o=0x12345678; stall_o high 1 cycle; MemData_o=0.
- Two consecutive loads, each acked after 1 cycle → two req pulses separated by exactly 1 low cycle; MEM/WB order is bubble, load1, bubble, load2.
- TIMEOUT_CYC=4, ack never arrives → dm_req_o high 4 cycles, then drops; timeout_o=1 and stays set; MemData_o=0; pipeline resumes.
- Assert rst_i in the 2nd WAIT cycle → all outputs 0 immediately; after release a stray dm_ack_i is ignored and no spurious MEM/WB write occurs.

Source files
------------

// File: rtl/mem_access_stage.sv
// Memory-stage controller: runs a req/ack handshake with a variable-latency
// data memory, stalls the upstream pipeline while an access is outstanding,
// and registers the MEM/WB pipeline outputs consumed by write-back.
module mem_access_stage #(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        RegWrite_i,
    input  logic        MemtoReg_i,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    input  logic [31:0] ALUout_i,
    input  logic [31:0] DM_writedata_i,
    input  logic [4:0]  rd_i,
    output logic        dm_req_o,
    output logic        dm_we_o,
    output logic [31:0] dm_addr_o,
    output logic [31:0] dm_wdata_o,
    input  logic        dm_ack_i,
    input  logic [31:0] dm_rdata_i,
    output logic        stall_o,
    output logic        RegWrite_o,
    output logic        MemtoReg_o,
    output logic [31:0] ALUout_o,
    output logic [31:0] MemData_o,
    output logic [4:0]  rd_o,
    output logic        timeout_o
);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    localparam logic [15:0] LAST_CNT = 16'(TIMEOUT_CYC - 1);

    state_t      state;
    state_t      state_nxt;
    logic [15:0] wait_cnt;
    logic        access;
    logic        start;
    logic        done;
    logic        timeout_hit;
    logic        stall;

    // Next-state decode plus the combinational stall / completion strobes.
    always_comb begin
        state_nxt   = state;
        access      = MemRead_i | MemWrite_i;
        start       = 1'b0;
        done        = 1'b0;
        timeout_hit = 1'b0;
        stall       = 1'b0;
        case (state)
            S_IDLE: begin
                if (access) begin
                    start     = 1'b1;
                    stall     = 1'b1;
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (dm_ack_i) begin
                    done = 1'b1;
                end else if (wait_cnt == LAST_CNT) begin
                    done        = 1'b1;
                    timeout_hit = 1'b1;
                end else begin
                    stall = 1'b1;
                end
                if (done) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Stall is gated by reset so it reads 0 while reset is held, even with an
    // access pending on the EX/MEM inputs.
    assign stall_o = stall & rst_i;

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Memory request registers, wait counter, MEM/WB registers and sticky timeout.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            dm_req_o   <= 1'b0;
            dm_we_o    <= 1'b0;
            dm_addr_o  <= '0;
            dm_wdata_o <= '0;
            wait_cnt   <= '0;
            RegWrite_o <= 1'b0;
            MemtoReg_o <= 1'b0;
            ALUout_o   <= '0;
            MemData_o  <= '0;
            rd_o       <= '0;
            timeout_o  <= 1'b0;
        end else begin
            if (start) begin
                dm_req_o   <= 1'b1;
                dm_we_o    <= MemWrite_i;
                dm_addr_o  <= ALUout_i;
                dm_wdata_o <= DM_writedata_i;
                wait_cnt   <= '0;
            end else if (state == S_WAIT) begin
                if (done) begin
                    dm_req_o <= 1'b0;
                end else begin
                    wait_cnt <= wait_cnt + 16'd1;
                end
            end

            // EX/MEM is frozen while stalled, so it still holds the completing
            // instruction when the stall drops.
            if (stall) begin
                RegWrite_o <= 1'b0;
                MemtoReg_o <= 1'b0;
                ALUout_o   <= '0;
                MemData_o  <= '0;
                rd_o       <= '0;
            end else begin
                RegWrite_o <= RegWrite_i;
                MemtoReg_o <= MemtoReg_i;
                ALUout_o   <= ALUout_i;
                rd_o       <= rd_i;
                MemData_o  <= (done && dm_ack_i && !dm_we_o) ? dm_rdata_i : '0;
            end

            if (timeout_hit) begin
                timeout_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Testbench for mem_access_stage: directed scenarios plus randomized
// instructions checked against a transaction-level expectation model.
module tb_mem_access_stage;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i;
    logic [31:0] ALUout_i, DM_writedata_i;
    logic [4:0]  rd_i;
    logic        dm_req_o, dm_we_o;
    logic [31:0] dm_addr_o, dm_wdata_o;
    logic        dm_ack_i;
    logic [31:0] dm_rdata_i;
    logic        stall_o, RegWrite_o, MemtoReg_o;
    logic [31:0] ALUout_o, MemData_o;
    logic [4:0]  rd_o;
    logic        timeout_o;

    int tests    = 0;
    int failures = 0;
    bit exp_timeout = 1'b0;

    mem_access_stage #(.TIMEOUT_CYC(TO)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .RegWrite_i     (RegWrite_i),
        .MemtoReg_i     (MemtoReg_i),
        .MemRead_i      (MemRead_i),
        .MemWrite_i     (MemWrite_i),
        .ALUout_i       (ALUout_i),
        .DM_writedata_i (DM_writedata_i),
        .rd_i           (rd_i),
        .dm_req_o       (dm_req_o),
        .dm_we_o        (dm_we_o),
        .dm_addr_o      (dm_addr_o),
        .dm_wdata_o     (dm_wdata_o),
        .dm_ack_i       (dm_ack_i),
        .dm_rdata_i     (dm_rdata_i),
        .stall_o        (stall_o),
        .RegWrite_o     (RegWrite_o),
        .MemtoReg_o     (MemtoReg_o),
        .ALUout_o       (ALUout_o),
        .MemData_o      (MemData_o),
        .rd_o           (rd_o),
        .timeout_o      (timeout_o)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Presents one instruction on EX/MEM (held while stalled) and plays the
    // memory side: ack arrives in the lat-th cycle after dm_req_o rises unless
    // 'never' is set. Expectations come from the instruction-level rules.
    task automatic run_instr(input bit rw, input bit mt, input bit rd_en, input bit wr_en,
                             input logic [31:0] alu, input logic [31:0] wdata,
                             input logic [4:0] rd, input int lat, input bit never,
                             input logic [31:0] rdval, input bit stray);
        bit          acc;
        bit          is_read;
        bit          timed;
        int          exp_stall;
        logic [31:0] exp_md;
        int          stalls;
        int          reqs;
        int          cyc;
        bit          fin;

        acc       = rd_en | wr_en;
        is_read   = rd_en & ~wr_en;
        timed     = acc && (never || lat > int'(TO));
        exp_stall = !acc ? 0 : (timed ? int'(TO) : lat);
        exp_md    = (acc && is_read && !timed) ? rdval : 32'h0;
        stalls    = 0;
        reqs      = 0;
        cyc       = 0;
        fin       = 1'b0;

        RegWrite_i     = rw;
        MemtoReg_i     = mt;
        MemRead_i      = rd_en;
        MemWrite_i     = wr_en;
        ALUout_i       = alu;
        DM_writedata_i = wdata;
        rd_i           = rd;

        while (!fin && cyc < 40) begin
            dm_ack_i   = (cyc == 0) ? stray : (!never && cyc == lat);
            dm_rdata_i = (cyc == lat) ? rdval : $urandom;
            @(negedge clk);
            if (cyc == 0) check_eq("req_low_at_issue", dm_req_o, 0);
            if (dm_req_o) begin
                reqs++;
                check_eq("dm_addr", dm_addr_o, alu);
                check_eq("dm_we", dm_we_o, wr_en);
                if (wr_en) check_eq("dm_wdata", dm_wdata_o, wdata);
            end
            if (stall_o) stalls++;
            else fin = 1'b1;
            @(posedge clk);
            #1;
            if (!fin) begin
                check_eq("bubble_ctrl", {RegWrite_o, MemtoReg_o, rd_o}, 0);
                check_eq("bubble_data", ALUout_o | MemData_o, 0);
            end
            cyc++;
        end
        dm_ack_i = 1'b0;

        if (timed) exp_timeout = 1'b1;
        check_eq("completed", fin, 1);
        check_eq("stall_cycles", stalls, exp_stall);
        check_eq("req_cycles", reqs, exp_stall);
        check_eq("RegWrite_o", RegWrite_o, rw);
        check_eq("MemtoReg_o", MemtoReg_o, mt);
        check_eq("ALUout_o", ALUout_o, alu);
        check_eq("rd_o", rd_o, rd);
        check_eq("MemData_o", MemData_o, exp_md);
        check_eq("req_after", dm_req_o, 0);
        check_eq("timeout_o", timeout_o, exp_timeout);
    endtask

    initial begin
        int k;
        rst            = 1'b0;
        RegWrite_i     = 1'b0;
        MemtoReg_i     = 1'b0;
        MemRead_i      = 1'b1;
        MemWrite_i     = 1'b0;
        ALUout_i       = '0;
        DM_writedata_i = '0;
        rd_i           = '0;
        dm_ack_i       = 1'b0;
        dm_rdata_i     = '0;

        // Reset state, with an access pending on the inputs.
        #12;
        check_eq("rst_stall", stall_o, 0);
        check_eq("rst_req", dm_req_o, 0);
        check_eq("rst_memwb", {RegWrite_o, MemtoReg_o, rd_o, timeout_o}, 0);
        check_eq("rst_data", ALUout_o | MemData_o | dm_addr_o, 0);
        MemRead_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Directed scenarios.
        run_instr(1, 0, 0, 0, 32'h10, 32'h0, 5'd5, 1, 0, 32'h0, 0);
        run_instr(1, 1, 1, 0, 32'h100, 32'h0, 5'd6, 3, 0, 32'hCAFEF00D, 0);
        run_instr(0, 0, 0, 1, 32'h200, 32'h12345678, 5'd0, 1, 0, 32'hDEADBEEF, 0);
        run_instr(1, 1, 1, 0, 32'h104, 32'h0, 5'd8, 1, 0, 32'h11111111, 0);
        run_instr(1, 1, 1, 0, 32'h108, 32'h0, 5'd9, 1, 0, 32'h22222222, 0);
        run_instr(1, 1, 1, 1, 32'h10C, 32'hA5A5A5A5, 5'd3, 2, 0, 32'h33333333, 1);
        run_instr(1, 1, 1, 0, 32'h110, 32'h0, 5'd4, TO, 0, 32'h44444444, 0);
        run_instr(1, 1, 1, 0, 32'h114, 32'h0, 5'd10, 1, 1, 32'h55555555, 0);
        run_instr(1, 0, 0, 0, 32'h20, 32'h0, 5'd11, 1, 0, 32'h0, 1);
        run_instr(1, 1, 1, 0, 32'h118, 32'h0, 5'd12, TO + 1, 0, 32'h66666666, 0);

        // Randomized instruction stream.
        for (int i = 0; i < 80; i++) begin
            k = $urandom_range(0, 3);
            run_instr($urandom_range(0, 1), $urandom_range(0, 1), (k == 1 || k == 3), (k >= 2),
                      $urandom, $urandom, 5'($urandom), $urandom_range(1, 6),
                      ($urandom_range(0, 9) == 0), $urandom, $urandom_range(0, 1));
        end

        // Reset in the second WAIT cycle abandons the access at once.
        RegWrite_i = 1'b1;
        MemtoReg_i = 1'b1;
        MemRead_i  = 1'b1;
        MemWrite_i = 1'b0;
        ALUout_i   = 32'h300;
        rd_i       = 5'd7;
        dm_ack_i   = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check_eq("pre_rst_req", dm_req_o, 1);
        #2;
        rst = 1'b0;
        #1;
        check_eq("midrst_req", dm_req_o, 0);
        check_eq("midrst_stall", stall_o, 0);
        check_eq("midrst_ctrl", {RegWrite_o, MemtoReg_o, rd_o, timeout_o}, 0);
        check_eq("midrst_data", ALUout_o | MemData_o, 0);
        exp_timeout = 1'b0;
        RegWrite_i = 1'b0;
        MemtoReg_i = 1'b0;
        MemRead_i  = 1'b0;
        ALUout_i   = '0;
        rd_i       = '0;
        dm_ack_i   = 1'b1;
        dm_rdata_i = 32'hBADBAD00;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_eq("post_rst_memdata", MemData_o, 0);
        check_eq("post_rst_ctrl", {RegWrite_o, dm_req_o, stall_o, timeout_o}, 0);
        dm_ack_i = 1'b0;

        for (int i = 0; i < 20; i++) begin
            k = $urandom_range(0, 3);
            run_instr($urandom_range(0, 1), $urandom_range(0, 1), (k == 1 || k == 3), (k >= 2),
                      $urandom, $urandom, 5'($urandom), $urandom_range(1, 6),
                      ($urandom_range(0, 9) == 0), $urandom, $urandom_range(0, 1));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
